// File: rtl/ad9837_pkg.sv
// Shared AD9837 definitions: SPI engine states, word width and control-word layout.
package ad9837_pkg;

    localparam int unsigned AD9837_WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_LO,
        SHIFT_HI,
        HOLD,
        GAP
    } spi_state_t;

    // Control register bit positions (D15:D14 = 2'b00 selects the control register)
    localparam int unsigned CTRL_B28     = 13;
    localparam int unsigned CTRL_HLB     = 12;
    localparam int unsigned CTRL_FSEL    = 11;
    localparam int unsigned CTRL_PSEL    = 10;
    localparam int unsigned CTRL_RESET   = 8;
    localparam int unsigned CTRL_SLEEP1  = 7;
    localparam int unsigned CTRL_SLEEP12 = 6;
    localparam int unsigned CTRL_OPBITEN = 5;
    localparam int unsigned CTRL_DIV2    = 3;
    localparam int unsigned CTRL_MODE    = 1;

    localparam logic [1:0] FREQ0_ADDR = 2'b01;
    localparam logic [1:0] FREQ1_ADDR = 2'b10;

endpackage

// File: rtl/ad9837_spi_master_half_tick.sv
// Divider issuing a one-cycle tick every CLK_DIV clocks; restart re-aligns the count.
module spi_half_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ad9837_spi_master.sv
// SPI mode-2 word transmitter driving AD9837 SCLK/SDATA/FSYNC with optional continuous framing.
module ad9837_spi_master
    import ad9837_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned WORD_W  = AD9837_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              cont,
    input  logic [WORD_W-1:0] tx_data,
    output logic              busy,
    output logic              tx_ack,
    output logic              sclk,
    output logic              ss_n,
    output logic              mosi
);

    localparam int unsigned BW = $clog2(WORD_W);
    localparam logic [BW-1:0] TOP_BIT = BW'(WORD_W - 1);

    spi_state_t        state, state_nxt;
    logic [WORD_W-1:0] shreg, shreg_nxt;
    logic [BW-1:0]     bit_cnt, bit_cnt_nxt;
    logic              sclk_nxt, ss_n_nxt, mosi_nxt, busy_nxt, ack_nxt;
    logic              tick;

    spi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .restart(state == IDLE),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b1;
            ss_n    <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            tx_ack  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            sclk    <= sclk_nxt;
            ss_n    <= ss_n_nxt;
            mosi    <= mosi_nxt;
            busy    <= busy_nxt;
            tx_ack  <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        sclk_nxt    = sclk;
        ss_n_nxt    = ss_n;
        mosi_nxt    = mosi;
        busy_nxt    = busy;
        ack_nxt     = 1'b0;

        unique case (state)
            IDLE: begin
                if (enable) begin
                    shreg_nxt   = tx_data;
                    bit_cnt_nxt = TOP_BIT;
                    mosi_nxt    = tx_data[WORD_W-1];
                    ack_nxt     = 1'b1;
                    ss_n_nxt    = 1'b0;
                    busy_nxt    = 1'b1;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    sclk_nxt  = 1'b0;
                    state_nxt = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                // The rising-edge decision is taken here so mosi moves on the same edge as sclk rises
                if (tick) begin
                    sclk_nxt  = 1'b1;
                    state_nxt = SHIFT_HI;
                    if (bit_cnt != '0) begin
                        shreg_nxt   = {shreg[WORD_W-2:0], 1'b0};
                        mosi_nxt    = shreg[WORD_W-2];
                        bit_cnt_nxt = bit_cnt - BW'(1);
                    end else if (cont) begin
                        shreg_nxt   = tx_data;
                        mosi_nxt    = tx_data[WORD_W-1];
                        bit_cnt_nxt = TOP_BIT;
                        ack_nxt     = 1'b1;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    sclk_nxt  = 1'b0;
                    state_nxt = SHIFT_LO;
                end
            end
            HOLD: begin
                if (tick) begin
                    ss_n_nxt  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (tick) begin
                    busy_nxt  = 1'b0;
                    mosi_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ad9837_spi_master.sv
// Bench for ad9837_spi_master: timing-formula reference model, per-cycle compare, falling-edge word decoder.
module tb_ad9837_spi_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        en     [2];
    logic        cnt    [2];
    logic [15:0] txd    [2];
    logic        busy_w [2];
    logic        ack_w  [2];
    logic        sclk_w [2];
    logic        ss_w   [2];
    logic        mosi_w [2];

    int divs [2] = '{4, 1};

    always #5 clk = ~clk;

    ad9837_spi_master #(.CLK_DIV(4), .WORD_W(16)) dut4 (
        .clk(clk), .reset(reset), .enable(en[0]), .cont(cnt[0]), .tx_data(txd[0]),
        .busy(busy_w[0]), .tx_ack(ack_w[0]), .sclk(sclk_w[0]), .ss_n(ss_w[0]), .mosi(mosi_w[0])
    );

    ad9837_spi_master #(.CLK_DIV(1), .WORD_W(16)) dut1 (
        .clk(clk), .reset(reset), .enable(en[1]), .cont(cnt[1]), .tx_data(txd[1]),
        .busy(busy_w[1]), .tx_ack(ack_w[1]), .sclk(sclk_w[1]), .ss_n(ss_w[1]), .mosi(mosi_w[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    function automatic void chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endfunction

    // Reference model: a frame is described by its start edge and its word list
    bit          active [2];
    int          c_n    [2];
    int          m_nw   [2];
    logic [15:0] m_w    [2][2];
    int          plan_nw[2];
    logic [15:0] plan_w [2][2];

    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                active[d] = 1'b0;
            end else if (en[d] && (!active[d] ||
                         cyc - c_n[d] > 32 * divs[d] * m_nw[d] + 2 * divs[d])) begin
                active[d]  = 1'b1;
                c_n[d]     = cyc;
                m_nw[d]    = plan_nw[d];
                m_w[d][0]  = plan_w[d][0];
                m_w[d][1]  = plan_w[d][1];
            end
        end
    end

    function automatic void model_out(input int d, output logic s, output logic ss,
                                      output logic m, output logic b, output logic a);
        int dv = divs[d];
        int t  = cyc - c_n[d];
        int l  = 32 * dv * m_nw[d];
        int bi;
        s = 1'b1; ss = 1'b1; m = 1'b0; b = 1'b0; a = 1'b0;
        if (reset || !active[d] || t >= l + 2 * dv) return;
        b  = 1'b1;
        ss = (t < l + dv) ? 1'b0 : 1'b1;
        a  = (t < l) && (t % (32 * dv) == 0);
        s  = !(((t / dv) % 2 == 1) && (t < l));
        if (t < l) begin
            bi = t / (2 * dv);
            m  = m_w[d][bi / 16][15 - (bi % 16)];
        end else begin
            m  = m_w[d][m_nw[d] - 1][0];
        end
    endfunction

    always @(negedge clk) begin
        logic es, ess, em, eb, ea;
        for (int d = 0; d < 2; d++) begin
            model_out(d, es, ess, em, eb, ea);
            chk($sformatf("d%0d_sclk", d), int'(sclk_w[d]), int'(es));
            chk($sformatf("d%0d_ss_n", d), int'(ss_w[d]),   int'(ess));
            chk($sformatf("d%0d_mosi", d), int'(mosi_w[d]), int'(em));
            chk($sformatf("d%0d_busy", d), int'(busy_w[d]), int'(eb));
            chk($sformatf("d%0d_ack",  d), int'(ack_w[d]),  int'(ea));
        end
    end

    // Device-side view: shift mosi on each falling sclk while ss_n is low
    logic        prev_sclk [2];
    logic        prev_ss   [2];
    logic [15:0] sh        [2];
    int          nb        [2];
    int          falls     [2];
    int          last_falls[2];
    int          dec_n     [2];
    logic [15:0] dec_w     [2][32];

    initial begin
        for (int d = 0; d < 2; d++) begin
            dec_n[d] = 0;
            last_falls[d] = 0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                nb[d] = 0;
                falls[d] = 0;
                prev_sclk[d] = 1'b1;
                prev_ss[d] = 1'b1;
            end else begin
                if (prev_sclk[d] && !sclk_w[d] && !ss_w[d]) begin
                    sh[d] = {sh[d][14:0], mosi_w[d]};
                    nb[d]++;
                    falls[d]++;
                    if (nb[d] == 16) begin
                        dec_w[d][dec_n[d] % 32] = sh[d];
                        dec_n[d]++;
                        nb[d] = 0;
                    end
                end
                if (!prev_ss[d] && ss_w[d]) begin
                    last_falls[d] = falls[d];
                    falls[d] = 0;
                    nb[d] = 0;
                end
                prev_sclk[d] = sclk_w[d];
                prev_ss[d] = ss_w[d];
            end
        end
    end

    task automatic wait_ack(input int d, input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            @(negedge clk);
            if (ack_w[d]) break;
        end
        if (i == limit) chk($sformatf("d%0d_ack_timeout", d), 0, 1);
    endtask

    task automatic send(input int d, input logic [15:0] w0, input logic [15:0] w1,
                        input int nw, input int poke, input int exp_ack2, input int exp_busy);
        int base, t0, n_ack, i;
        base = dec_n[d];
        plan_w[d][0] = w0;
        plan_w[d][1] = w1;
        plan_nw[d]   = nw;
        txd[d] = w0;
        cnt[d] = (nw > 1);
        en[d]  = 1'b1;
        wait_ack(d, 300);
        t0 = cyc;
        en[d] = 1'b0;
        n_ack = 1;
        if (nw > 1) txd[d] = w1;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (poke > 0 && cyc == t0 + poke - 1) en[d] = 1'b1;
            if (poke > 0 && cyc == t0 + poke) en[d] = 1'b0;
            if (ack_w[d]) begin
                n_ack++;
                chk($sformatf("d%0d_ack2_offset", d), cyc - t0, exp_ack2);
                cnt[d] = 1'b0;
            end
            if (!busy_w[d]) break;
        end
        chk($sformatf("d%0d_busy_low_offset", d), cyc - t0, exp_busy);
        chk($sformatf("d%0d_ack_count", d), n_ack, nw);
        chk($sformatf("d%0d_words", d), dec_n[d] - base, nw);
        chk($sformatf("d%0d_word0", d), int'(dec_w[d][base % 32]), int'(w0));
        if (nw > 1) chk($sformatf("d%0d_word1", d), int'(dec_w[d][(base + 1) % 32]), int'(w1));
        chk($sformatf("d%0d_falls", d), last_falls[d], 16 * nw);
    endtask

    initial begin
        int t0, a1, a2, a3, base;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0; cnt[d] = 1'b0; txd[d] = '0;
            plan_nw[d] = 1; plan_w[d][0] = '0; plan_w[d][1] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_sclk", int'(sclk_w[0]), 1);
        chk("rst_ss_n", int'(ss_w[0]), 1);
        chk("rst_busy", int'(busy_w[0]), 0);
        chk("rst_mosi", int'(mosi_w[0]), 0);
        chk("rst_ack",  int'(ack_w[0]), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        send(0, 16'h2100, 16'h0000, 1, 0, 0, 136);
        @(negedge clk);
        send(0, 16'h4312, 16'h4002, 2, 0, 128, 264);
        @(negedge clk);

        send(1, 16'hFFFF, 16'h0000, 1, 0, 0, 34);
        chk("d1_ss_n_between", int'(ss_w[1]), 1);
        send(1, 16'h0000, 16'h0000, 1, 0, 0, 34);
        @(negedge clk);

        send(0, 16'h1357, 16'h0000, 1, 50, 0, 136);
        @(negedge clk);

        // Abort a frame with reset between clock edges
        plan_w[0][0] = 16'hBEEF; plan_nw[0] = 1;
        txd[0] = 16'hBEEF; cnt[0] = 1'b0; en[0] = 1'b1;
        wait_ack(0, 300);
        t0 = cyc;
        en[0] = 1'b0;
        base = dec_n[0];
        while (cyc < t0 + 59) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_ss_n", int'(ss_w[0]), 1);
        chk("abort_sclk", int'(sclk_w[0]), 1);
        chk("abort_busy", int'(busy_w[0]), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_no_word", dec_n[0] - base, 0);
        send(0, 16'hC000, 16'h0000, 1, 0, 0, 136);
        @(negedge clk);

        // enable held high: frames restart as soon as the block is idle again
        base = dec_n[0];
        plan_w[0][0] = 16'hA5C3; plan_nw[0] = 1;
        txd[0] = 16'hA5C3; cnt[0] = 1'b0; en[0] = 1'b1;
        wait_ack(0, 300); a1 = cyc;
        wait_ack(0, 300); a2 = cyc;
        wait_ack(0, 300); a3 = cyc;
        en[0] = 1'b0;
        chk("held_gap1", a2 - a1, 137);
        chk("held_gap2", a3 - a2, 137);
        for (int i = 0; i < 300 && busy_w[0]; i++) @(negedge clk);
        chk("held_idle", int'(busy_w[0]), 0);
        chk("held_words", dec_n[0] - base, 3);
        for (int k = 0; k < 3; k++) chk("held_word", int'(dec_w[0][(base + k) % 32]), 16'hA5C3);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ad9837_spi_master.md
# ad9837_spi_master

Serial transmit engine between the AD9837 control block and the AD9837 DDS pins. It accepts 16-bit command/data words from the control block through an enable/busy/cont handshake. It shifts each word out MSB-first on `sclk`/`mosi` in SPI mode 2 (CPOL=1, device samples on falling `sclk`). It frames each word, or each back-to-back run of words, with active-low `ss_n` (FSYNC).

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `sclk` half-period; legal range ≥1.
- `WORD_W`, default 16: bits per word.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; one clock domain only.
- `enable`  in  1  start request; level-sampled only while idle.
- `cont`  in  1  continue framing with the next word; sampled at the last rising `sclk` edge of each word.
- `tx_data`  in  `WORD_W`  word to send; latched on acceptance.
- `busy`  out  1  high from acceptance until the post-frame gap ends.
- `tx_ack`  out  1  one-cycle pulse when `tx_data` is latched; the control block may change `tx_data` from the next cycle.
- `sclk`  out  1  serial clock; idles high.
- `ss_n`  out  1  FSYNC; idles high.
- `mosi`  out  1  serial data.

## Operation
- States: IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP.
- Reset values, applied immediately: state=IDLE, `sclk`=1, `ss_n`=1, `mosi`=0, `busy`=0, `tx_ack`=0, shift register=0, bit count=0, divider=0.
- IDLE:
  - If `enable`=1: latch `tx_data`, pulse `tx_ack`, set `ss_n`=0, `busy`=1, `mosi`=`tx_data[WORD_W-1]`, go to SETUP.
  - If `enable` is still high when the block returns to IDLE, the next frame starts.
- SETUP: hold for `CLK_DIV` cycles, then drive `sclk`=0 and go to SHIFT_LO.
- SHIFT_LO: hold for `CLK_DIV` cycles, then drive `sclk`=1 and go to SHIFT_HI.
- SHIFT_HI on rising `sclk`, not the last bit: shift left, `mosi`=next bit, hold `CLK_DIV` cycles, fall, return to SHIFT_LO.
- SHIFT_HI, last bit, `cont`=1:
  - Latch the new `tx_data`, pulse `tx_ack`, set `mosi` to its MSB.
  - `ss_n` stays low; the next falling edge comes `CLK_DIV` cycles later with no extra gap.
- SHIFT_HI, last bit, `cont`=0: go to HOLD.
- HOLD: after `CLK_DIV` cycles, set `ss_n`=1 and go to GAP.
- GAP: after `CLK_DIV` cycles, set `busy`=0, `mosi`=0, go to IDLE.
- `enable` while `busy`=1 is ignored. `tx_data` changes outside the `tx_ack` cycle have no effect.
- Reset mid-frame: outputs return to idle values asynchronously. The device discards the partial word because `ss_n` rises.
- Bit counter: width `$clog2(WORD_W)`, counts `WORD_W-1` down to 0.
- Divider counter: width `$clog2(CLK_DIV+1)`, reloaded on every phase change.

## Timing
- Let N be the edge at which `enable` is accepted. `ss_n`↓, `busy`↑, `tx_ack`↑ and MSB on `mosi` all occur at N.
- Falling `sclk` for bit i (i=0 = MSB): N + `CLK_DIV`·(1+2i).
- Rising `sclk` for bit i: N + `CLK_DIV`·(2+2i).
- `mosi` changes only at rising `sclk` or at N. This gives `CLK_DIV` cycles of setup and hold around each falling edge.
- Single word, `cont`=0: last rise at N+32·`CLK_DIV`, `ss_n`↑ at N+33·`CLK_DIV`, `busy`↓ at N+34·`CLK_DIV`. With `CLK_DIV`=4, `busy`↓ at N+136.
- Earliest next acceptance is the edge where `busy`=0 is first seen in IDLE.
- Continuous mode: word k+1 is latched at N+32·`CLK_DIV`·(k+1). `sclk` period stays uniform across the word boundary.
- `tx_ack` is exactly one cycle wide and never asserts outside an acceptance or continuation.

## Structure
- Shared package `ad9837_pkg`:
  - State enum `spi_state_t`.
  - `AD9837_WORD_W`=16.
  - AD9837 control-word bit positions (B28, HLB, FSEL, PSEL, RESET, SLEEP1, SLEEP12, OPBITEN, DIV2, MODE) and register address prefixes (FREQ0=2'b01, FREQ1=2'b10), also used by the control block.
- Sub-module `spi_half_tick`: divider producing a one-cycle tick every `CLK_DIV` cycles, with a synchronous restart input. The FSM advances phases only on the tick.

## Test plan
- `CLK_DIV`=4, `tx_data`=16'h2100, single pulse on `enable`:
  - 16 falling edges; decoded word on falling edges is 16'h2100.
  - `ss_n` low N..N+132, `busy` low at N+136, one `tx_ack` at N.
- `cont`=1 with words 16'h4312, 16'h4002, then `cont`=0:
  - 32 uninterrupted `sclk` cycles under one `ss_n` low.
  - `tx_ack` at N and N+128; decoded words match.
- `CLK_DIV`=1, `tx_data`=16'hFFFF then 16'h0000 as separate frames:
  - `sclk` period of 2 cycles; correct words.
  - `ss_n` high at least 1 cycle between frames.
- `enable` pulsed at N+50 during a frame: ignored, no extra `tx_ack`, frame unchanged.
- `reset` asserted at N+60:
  - `ss_n`=1, `sclk`=1, `busy`=0 without waiting for a clock edge.
  - After release, a new 16'hC000 frame transmits correctly.
- `enable` held high continuously: back-to-back frames, each separated by ≥`CLK_DIV` cycles of `ss_n` high.
